// File: rtl/bp_pkg.sv
// Shared definitions for the fetch-stage branch predictor: 2-bit direction
// counter encodings and the reset/allocation counter values.
package bp_pkg;

   typedef enum logic [1:0] {
      SNT = 2'b00,
      WNT = 2'b01,
      WT  = 2'b10,
      ST  = 2'b11
   } bp_ctr_e;

   localparam bp_ctr_e BP_CTR_RST   = WNT;
   localparam bp_ctr_e BP_CTR_ALLOC = WT;

endpackage

// File: rtl/bp_sat_counter.sv
// Combinational next-state for a 2-bit saturating direction counter.
module bp_sat_counter
   import bp_pkg::*;
(
   input  logic [1:0] ctr_i,
   input  logic       taken_i,
   output logic [1:0] ctr_o
);

   always_comb begin
      ctr_o = ctr_i;
      if (taken_i && (ctr_i != ST)) begin
         ctr_o = ctr_i + 2'd1;
      end else if (!taken_i && (ctr_i != SNT)) begin
         ctr_o = ctr_i - 2'd1;
      end
   end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped dynamic branch predictor: zero-latency lookup at fetch,
// training and mispredict detection from execute, plus event counters.
module branch_predictor
   import bp_pkg::*;
#(
   parameter  int unsigned ENTRIES = 32,
   localparam int unsigned IDX_W   = $clog2(ENTRIES)
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc_f,
   output logic        pred_taken,
   output logic [31:0] pred_next_pc,
   input  logic        upd_valid,
   input  logic [31:0] upd_pc,
   input  logic        upd_taken,
   input  logic [31:0] upd_target,
   input  logic        upd_pred_taken,
   input  logic [31:0] upd_pred_next_pc,
   output logic        mispredict,
   input  logic        bp_clear,
   output logic [31:0] branch_count,
   output logic [31:0] mispredict_count
);

   localparam int unsigned TAG_W = 30 - IDX_W;

   logic              valid_q  [ENTRIES];
   logic [1:0]        ctr_q    [ENTRIES];
   logic [TAG_W-1:0]  tag_q    [ENTRIES];
   logic [31:0]       target_q [ENTRIES];

   logic [31:0]       branch_cnt_q, branch_cnt_d;
   logic [31:0]       mispred_cnt_q, mispred_cnt_d;

   logic [IDX_W-1:0]  idx_f, idx_u;
   logic [TAG_W-1:0]  tag_f, tag_u;
   logic              hit_f, hit_u;
   logic [1:0]        ctr_nxt;
   logic [31:0]       actual_next;
   logic              train_en;

   assign idx_f = pc_f[IDX_W+1:2];
   assign tag_f = pc_f[31:IDX_W+2];
   assign idx_u = upd_pc[IDX_W+1:2];
   assign tag_u = upd_pc[31:IDX_W+2];

   assign hit_f        = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
   assign pred_taken   = hit_f && ctr_q[idx_f][1];
   assign pred_next_pc = pred_taken ? target_q[idx_f] : pc_f + 32'd4;

   assign hit_u       = valid_q[idx_u] && (tag_q[idx_u] == tag_u);
   assign actual_next = upd_taken ? upd_target : upd_pc + 32'd4;
   assign mispredict  = upd_valid && (upd_pred_next_pc != actual_next);
   // bp_clear suppresses training and allocation in the same cycle
   assign train_en    = upd_valid && !bp_clear;

   bp_sat_counter u_sat (
      .ctr_i   (ctr_q[idx_u]),
      .taken_i (upd_taken),
      .ctr_o   (ctr_nxt)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < ENTRIES; i++) begin
            valid_q[i] <= 1'b0;
            ctr_q[i]   <= BP_CTR_RST;
         end
      end else if (bp_clear) begin
         for (int unsigned i = 0; i < ENTRIES; i++) begin
            valid_q[i] <= 1'b0;
         end
      end else if (upd_valid) begin
         if (hit_u) begin
            ctr_q[idx_u] <= ctr_nxt;
         end else if (upd_taken) begin
            valid_q[idx_u] <= 1'b1;
            ctr_q[idx_u]   <= BP_CTR_ALLOC;
         end
      end
   end

   // Tag/target carry no reset; valid gates their use
   always_ff @(posedge clk) begin
      if (train_en && upd_taken && !rst) begin
         tag_q[idx_u]    <= tag_u;
         target_q[idx_u] <= upd_target;
      end
   end

   always_comb begin
      branch_cnt_d  = branch_cnt_q + {31'd0, upd_valid};
      mispred_cnt_d = mispred_cnt_q + {31'd0, mispredict};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         branch_cnt_q  <= '0;
         mispred_cnt_q <= '0;
      end else begin
         branch_cnt_q  <= branch_cnt_d;
         mispred_cnt_q <= mispred_cnt_d;
      end
   end

   assign branch_count     = branch_cnt_q;
   assign mispredict_count = mispred_cnt_q;

   logic unused_ok;
   assign unused_ok = ^{pc_f[1:0], upd_pc[1:0], upd_pred_taken};

endmodule

// File: tb/tb_branch_predictor.sv
// Randomized and directed bench for branch_predictor against a behavioural
// table model (per-entry records, integer counters).
module tb_branch_predictor;

   localparam int ENTRIES = 32;
   localparam int IDX_W   = 5;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] pc_f = '0;
   logic        pred_taken;
   logic [31:0] pred_next_pc;
   logic        upd_valid = 1'b0;
   logic [31:0] upd_pc = '0;
   logic        upd_taken = 1'b0;
   logic [31:0] upd_target = '0;
   logic        upd_pred_taken = 1'b0;
   logic [31:0] upd_pred_next_pc = '0;
   logic        mispredict;
   logic        bp_clear = 1'b0;
   logic [31:0] branch_count;
   logic [31:0] mispredict_count;

   branch_predictor #(.ENTRIES(ENTRIES)) dut (
      .clk              (clk),
      .rst              (rst),
      .pc_f             (pc_f),
      .pred_taken       (pred_taken),
      .pred_next_pc     (pred_next_pc),
      .upd_valid        (upd_valid),
      .upd_pc           (upd_pc),
      .upd_taken        (upd_taken),
      .upd_target       (upd_target),
      .upd_pred_taken   (upd_pred_taken),
      .upd_pred_next_pc (upd_pred_next_pc),
      .mispredict       (mispredict),
      .bp_clear         (bp_clear),
      .branch_count     (branch_count),
      .mispredict_count (mispredict_count)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_bad = 0;

   bit          m_valid [ENTRIES];
   logic [31:0] m_tag   [ENTRIES];
   logic [31:0] m_tgt   [ENTRIES];
   int          m_ctr   [ENTRIES];
   logic [31:0] m_bc, m_mc;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int m_idx(input logic [31:0] pc);
      return int'((pc / 4) % ENTRIES);
   endfunction

   function automatic logic [31:0] m_tagof(input logic [31:0] pc);
      return pc >> (IDX_W + 2);
   endfunction

   function automatic bit m_hit(input logic [31:0] pc);
      return m_valid[m_idx(pc)] && (m_tag[m_idx(pc)] == m_tagof(pc));
   endfunction

   function automatic bit m_pred(input logic [31:0] pc);
      return m_hit(pc) && (m_ctr[m_idx(pc)] >= 2);
   endfunction

   function automatic logic [31:0] m_next(input logic [31:0] pc);
      return m_pred(pc) ? m_tgt[m_idx(pc)] : pc + 32'd4;
   endfunction

   function automatic bit m_misp();
      logic [31:0] actual;
      actual = upd_taken ? upd_target : upd_pc + 32'd4;
      return upd_valid && (upd_pred_next_pc != actual);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < ENTRIES; i++) begin
         m_valid[i] = 1'b0;
         m_ctr[i]   = 1;
      end
      m_bc = '0;
      m_mc = '0;
   endtask

   task automatic model_edge();
      int i;
      i = m_idx(upd_pc);
      if (upd_valid) m_bc = m_bc + 32'd1;
      if (m_misp()) m_mc = m_mc + 32'd1;
      if (bp_clear) begin
         for (int k = 0; k < ENTRIES; k++) m_valid[k] = 1'b0;
      end else if (upd_valid) begin
         if (m_hit(upd_pc)) begin
            m_ctr[i] = upd_taken ? ((m_ctr[i] < 3) ? m_ctr[i] + 1 : 3)
                                 : ((m_ctr[i] > 0) ? m_ctr[i] - 1 : 0);
            if (upd_taken) m_tgt[i] = upd_target;
         end else if (upd_taken) begin
            m_valid[i] = 1'b1;
            m_tag[i]   = m_tagof(upd_pc);
            m_tgt[i]   = upd_target;
            m_ctr[i]   = 2;
         end
      end
   endtask

   task automatic drive(input logic [31:0] pcf, input logic v, input logic [31:0] upc,
                        input logic tk, input logic [31:0] tgt, input logic [31:0] pnp,
                        input logic clr);
      pc_f             = pcf;
      upd_valid        = v;
      upd_pc           = upc;
      upd_taken        = tk;
      upd_target       = tgt;
      upd_pred_next_pc = pnp;
      upd_pred_taken   = (pnp != upc + 32'd4);
      bp_clear         = clr;
   endtask

   // Called at a negedge with inputs already driven; ends at the next negedge.
   task automatic cycle();
      #1;
      chk("pred_taken",       {31'd0, pred_taken}, {31'd0, m_pred(pc_f)});
      chk("pred_next_pc",     pred_next_pc,        m_next(pc_f));
      chk("mispredict",       {31'd0, mispredict}, {31'd0, m_misp()});
      chk("branch_count",     branch_count,        m_bc);
      chk("mispredict_count", mispredict_count,    m_mc);
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic idle(input logic [31:0] pcf);
      drive(pcf, 1'b0, '0, 1'b0, '0, '0, 1'b0);
   endtask

   logic [31:0] pool [8];
   logic [31:0] bc_before;

   initial begin
      pool[0] = 32'h0000_1000; pool[1] = 32'h0000_1080; pool[2] = 32'h0000_1004;
      pool[3] = 32'h0000_2000; pool[4] = 32'h0000_2100; pool[5] = 32'hFFFF_FFFC;
      pool[6] = 32'h0000_0000; pool[7] = 32'h0000_1008;
      model_reset();

      // Reset state while rst is held
      idle(32'h0000_1000);
      @(negedge clk);
      #1;
      chk("rst_pred_taken", {31'd0, pred_taken}, 32'd0);
      chk("rst_next_pc",    pred_next_pc, 32'h0000_1004);
      chk("rst_bc",         branch_count, 32'd0);
      chk("rst_mc",         mispredict_count, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      cycle();

      // Allocate on taken miss, then hit
      drive(32'h0000_1000, 1'b1, 32'h0000_1000, 1'b1, 32'h0000_2000, 32'h0000_1004, 1'b0);
      #1 chk("alloc_misp", {31'd0, mispredict}, 32'd1);
      cycle();
      idle(32'h0000_1000);
      #1;
      chk("hit_taken", {31'd0, pred_taken}, 32'd1);
      chk("hit_next",  pred_next_pc, 32'h0000_2000);
      chk("hit_mc",    mispredict_count, 32'd1);
      cycle();

      // Same index, different tag
      idle(32'h0000_1080);
      #1 chk("alias_next", pred_next_pc, 32'h0000_1084);
      cycle();

      // Saturate, then step back down
      for (int k = 0; k < 4; k++) begin
         drive(32'h0000_1000, 1'b1, 32'h0000_1000, 1'b1, 32'h0000_2000, 32'h0000_2000, 1'b0);
         cycle();
      end
      drive(32'h0000_1000, 1'b1, 32'h0000_1000, 1'b0, 32'h0000_2000, 32'h0000_2000, 1'b0);
      cycle();
      #1 chk("sat_nt1_taken", {31'd0, pred_taken}, 32'd1);
      drive(32'h0000_1000, 1'b1, 32'h0000_1000, 1'b0, 32'h0000_2000, 32'h0000_2000, 1'b0);
      cycle();
      idle(32'h0000_1000);
      #1;
      chk("sat_nt2_taken", {31'd0, pred_taken}, 32'd0);
      chk("sat_nt2_next",  pred_next_pc, 32'h0000_1004);

      // Lookup sees pre-update state in the update cycle
      drive(32'h0000_1000, 1'b1, 32'h0000_1000, 1'b1, 32'h0000_2000, 32'h0000_1004, 1'b0);
      #1 chk("samecyc_old", {31'd0, pred_taken}, 32'd0);
      cycle();
      idle(32'h0000_1000);
      #1 chk("samecyc_new", {31'd0, pred_taken}, 32'd1);
      cycle();

      // Clear beats a same-cycle update
      bc_before = branch_count;
      drive(32'h0000_1000, 1'b1, 32'h0000_1000, 1'b1, 32'h0000_3000, 32'h0000_2000, 1'b1);
      cycle();
      idle(32'h0000_1000);
      #1;
      chk("clr_taken", {31'd0, pred_taken}, 32'd0);
      chk("clr_bc",    branch_count, bc_before + 32'd1);
      cycle();

      // Async reset mid-update, update held across the release cycle
      drive(32'h0000_1000, 1'b1, 32'h0000_1000, 1'b1, 32'h0000_2000, 32'h0000_1004, 1'b0);
      cycle();
      drive(32'h0000_1000, 1'b1, 32'h0000_1000, 1'b1, 32'h0000_3000, 32'h0000_1004, 1'b0);
      #2 rst = 1'b1;
      #1;
      chk("mrst_taken", {31'd0, pred_taken}, 32'd0);
      chk("mrst_next",  pred_next_pc, 32'h0000_1004);
      chk("mrst_bc",    branch_count, 32'd0);
      chk("mrst_mc",    mispredict_count, 32'd0);
      chk("mrst_misp",  {31'd0, mispredict}, 32'd1);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      idle(32'h0000_1000);
      #1 chk("mrst_noalloc", {31'd0, pred_taken}, 32'd0);
      cycle();

      // Counter wrap
      force dut.branch_cnt_q = 32'hFFFF_FFFF;
      #1 release dut.branch_cnt_q;
      m_bc = 32'hFFFF_FFFF;
      drive(32'h0000_2000, 1'b1, 32'h0000_2000, 1'b0, 32'h0000_0000, 32'h0000_2004, 1'b0);
      cycle();
      idle(32'h0000_2000);
      #1 chk("wrap_bc", branch_count, 32'd0);
      cycle();

      // Randomized traffic
      for (int n = 0; n < 400; n++) begin
         logic [31:0] upc, tgt, pnp, pcf;
         logic tk;
         pcf = ($urandom_range(0, 3) == 0) ? ($urandom & 32'hFFFF_FFFC) : pool[$urandom_range(0, 7)];
         upc = pool[$urandom_range(0, 7)];
         tgt = {$urandom_range(0, 7), 2'b00} << 8;
         tk  = $urandom_range(0, 2) != 0;
         case ($urandom_range(0, 3))
            0, 1:    pnp = m_next(upc);
            2:       pnp = upc + 32'd4;
            default: pnp = tgt;
         endcase
         drive(pcf, $urandom_range(0, 3) != 0, upc, tk, tgt, pnp, $urandom_range(0, 40) == 0);
         cycle();
      end

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Dynamic branch predictor for the fetch stage. It is the forward-looking counterpart of execute-stage next-PC resolution.
- Each fetch cycle it looks up the current PC in a direct-mapped table and proposes a predicted next PC.
- When execute resolves a branch or jal, it receives the actual outcome and trains the table.
- It reports mispredicts and keeps branch and mispredict counters for the CSR and benchmark path.

## Interface
Parameters:
- `ENTRIES`, default 32: number of table entries; must be a power of two, minimum 4.
- `IDX_W`, default $clog2(ENTRIES): index width; derived, never overridden.

Ports:
- `clk`  in  1  core clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `pc_f`  in  32  PC of the instruction being fetched.
- `pred_taken`  out  1  prediction for `pc_f`: taken.
- `pred_next_pc`  out  32  predicted next PC for `pc_f`.
- `upd_valid`  in  1  execute is resolving a control-flow instruction this cycle.
- `upd_pc`  in  32  PC of the resolved instruction.
- `upd_taken`  in  1  actual direction (always 1 for jal).
- `upd_target`  in  32  actual taken target (the ALU result).
- `upd_pred_taken`  in  1  prediction made for this instruction at fetch, carried down the pipeline.
- `upd_pred_next_pc`  in  32  predicted next PC carried down the pipeline.
- `mispredict`  out  1  execute must redirect and flush.
- `bp_clear`  in  1  invalidate all entries (fence.i or CSR write).
- `branch_count`  out  32  number of resolved updates.
- `mispredict_count`  out  32  number of mispredicts.

## Operation
- **Entry contents:** each entry holds `valid`, `tag[31-IDX_W-2:0]`, `target[31:0]` and `ctr[1:0]`.
- **Address split:**
  - index = pc[IDX_W+1:2]
  - tag = pc[31:IDX_W+2]
  - pc[1:0] is ignored.
- **Lookup (combinational):**
  - hit = valid[idx] && tag[idx]==tag(pc_f).
  - `pred_taken` = hit && ctr[1].
  - `pred_next_pc` = pred_taken ? target[idx] : pc_f+4. The add is 32-bit and wraps.
- **Mispredict (combinational)** = upd_valid && (upd_pred_next_pc != (upd_taken ? upd_target : upd_pc+4)).
- **Update on upd_valid, upd hit:**
  - ctr saturates: +1 if taken (max 2'b11), −1 if not taken (min 2'b00).
  - If taken, target ← upd_target.
- **Update on upd_valid, upd miss:**
  - Taken: allocate. Set valid=1, tag, target=upd_target, ctr=2'b10 (weakly taken), overwriting any previous occupant.
  - Not taken: no table change.
- **bp_clear:** clears every `valid` bit; ctr, tag and target are left as-is.
  - If bp_clear and upd_valid occur in the same cycle, clear wins and no allocation or training happens.
  - Counters still update.
- **Counters:**
  - `branch_count` +1 per upd_valid.
  - `mispredict_count` +1 per cycle with mispredict=1.
  - Both are 32-bit and wrap from 0xFFFF_FFFF to 0.
  - Not affected by bp_clear.

## Timing
- Lookup latency is 0 cycles. `pred_*` depend only on `pc_f` and current table state.
- `mispredict` is valid in the same cycle as `upd_*`.
- Updates written at edge N are visible to lookups from cycle N+1.
- Lookup and update to the same index in the same cycle: the lookup sees the pre-update state.
- Back-to-back updates to the same index in consecutive cycles: each sees the previous write; counters step once per cycle.
- Reset (async, any cycle, including mid-update):
  - All valid=0, all ctr=2'b01, counters=0.
  - Outputs during and after reset: pred_taken=0, pred_next_pc=pc_f+4, mispredict follows its inputs.
  - An update in the reset-release cycle is ignored while rst=1.

## Structure
- Shared package `bp_pkg`:
  - ctr encodings SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11.
  - reset value `BP_CTR_RST`=WNT, allocation value `BP_CTR_ALLOC`=WT.
- One sub-module `bp_sat_counter`: combinational 2-bit saturating next-state (in ctr, taken → out ctr). It is instantiated once on the update path.
- Table arrays are flat register arrays in `branch_predictor`, so the async reset applies to valid and ctr. Tag and target need no reset.

## Test plan
- **Reset:** pulse rst mid-run, then look up pc_f=0x1000 → pred_taken=0, pred_next_pc=0x1004, branch_count=0, mispredict_count=0.
- **Allocate/hit:** update upd_pc=0x1000, taken, target 0x2000, upd_pred_next_pc=0x1004.
  - Same cycle: mispredict=1.
  - Next cycle: lookup 0x1000 → pred_taken=1, pred_next_pc=0x2000.
  - mispredict_count=1.
- **Saturation:**
  - Four taken updates at 0x1000 → ctr=ST.
  - Then one not-taken → still predicts taken.
  - A second not-taken → predicts not-taken, pred_next_pc=0x1004.
- **Aliasing:** with ENTRIES=32, after allocating 0x1000, look up 0x1080 (same index, different tag) → no hit, pred_next_pc=0x1084.
- **Same-cycle lookup/update and clear precedence:**
  - Update 0x1000 taken while looking up 0x1000 → that cycle still shows the old prediction.
  - bp_clear together with upd_valid → entry invalid afterwards, branch_count still increments.
- **Counter wrap:** force branch_count to 0xFFFF_FFFF, apply one update → 0x0000_0000.
